// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state type, widths and default timing for the ADC frame capture block
package adc_pkg;

  localparam int ADC_BITS          = 12;
  localparam int CH_W              = 4;
  localparam int DEF_CONVST_CYCLES = 2;
  localparam int DEF_CONV_CYCLES   = 80;
  localparam int DEF_SCK_DIV       = 2;
  localparam int DEF_NUM_CH        = 13;

  typedef enum logic [2:0] {
    IDLE,
    CONVST,
    CONV_WAIT,
    SHIFT,
    DONE
  } adc_state_e;

endpackage

// File: rtl/adc_sck_gen.sv
// rtl/adc_sck_gen.sv - ADC_SCK divider producing exactly ADC_BITS pulses per run, with sample and last-bit strobes
module adc_sck_gen
  import adc_pkg::*;
#(
  parameter int SCK_DIV = DEF_SCK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sck,
  output logic sample,
  output logic last
);

  localparam int PHASES = 2 * ADC_BITS;

  logic [15:0] div_cnt;
  logic [5:0]  phase;
  logic        div_end;

  assign div_end = (div_cnt == 16'(SCK_DIV - 1));
  // Strobes mark the cycle whose closing edge drives sck 1->0.
  assign sample  = run & div_end & sck;
  assign last    = sample & (phase == 6'(PHASES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= '0;
      sck     <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      phase   <= '0;
      sck     <= 1'b0;
    end else if (div_end) begin
      div_cnt <= '0;
      phase   <= last ? 6'd0 : phase + 6'd1;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/adc_frame_capture.sv
// rtl/adc_frame_capture.sv - ADC frame FSM, channel tagging and valid/ready result port; ADC_FRAME_BANK_EN adds a per-channel result bank
module adc_frame_capture
  import adc_pkg::*;
#(
  parameter int CONVST_CYCLES = DEF_CONVST_CYCLES,
  parameter int CONV_CYCLES   = DEF_CONV_CYCLES,
  parameter int SCK_DIV       = DEF_SCK_DIV,
  parameter int NUM_CH        = DEF_NUM_CH
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                ENABLE,
  input  logic [CH_W-1:0]     CH_ACTUAL,
  input  logic                ADC_SDO,
  output logic                ADC_CONVST,
  output logic                ADC_SCK,
  output logic                FRAME_FLAG,
  output logic [ADC_BITS-1:0] DATA,
  output logic [CH_W-1:0]     CH_TAG,
  output logic                DATA_VALID,
  input  logic                DATA_READY,
  output logic                OVERRUN,
  output logic                BUSY
`ifdef ADC_FRAME_BANK_EN
  ,
  input  logic [CH_W-1:0]     BANK_ADDR,
  output logic [ADC_BITS-1:0] BANK_DATA
`endif
);

  localparam logic [15:0] CONVST_LAST = 16'(CONVST_CYCLES - 1);
  localparam logic [15:0] CONV_LAST   = 16'(CONV_CYCLES - 1);

  adc_state_e          state;
  logic [15:0]         cnt;
  logic [CH_W-1:0]     ch_prev;
  logic [CH_W-1:0]     frame_tag;
  logic                prime;
  logic [ADC_BITS-1:0] shift_reg;
  logic                sck_sample;
  logic                sck_last;
  logic                publish;
  logic [ADC_BITS-1:0] pub_data;

  adc_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .run    (state == SHIFT),
    .sck    (ADC_SCK),
    .sample (sck_sample),
    .last   (sck_last)
  );

  // The final bit is folded in directly so the result is ready on the FRAME_FLAG edge.
  assign pub_data = {shift_reg[ADC_BITS-2:0], ADC_SDO};
  assign publish  = (state == SHIFT) & sck_last & prime;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      ch_prev    <= '0;
      frame_tag  <= '0;
      prime      <= 1'b0;
      shift_reg  <= '0;
      ADC_CONVST <= 1'b0;
      FRAME_FLAG <= 1'b0;
      DATA       <= '0;
      CH_TAG     <= '0;
      DATA_VALID <= 1'b0;
      OVERRUN    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      FRAME_FLAG <= 1'b0;
      OVERRUN    <= 1'b0;
      if (DATA_VALID && DATA_READY)
        DATA_VALID <= 1'b0;
      if (sck_sample)
        shift_reg <= pub_data;
      case (state)
        IDLE: begin
          prime <= 1'b0;
          if (ENABLE) begin
            state      <= CONVST;
            cnt        <= '0;
            ADC_CONVST <= 1'b1;
            BUSY       <= 1'b1;
            frame_tag  <= ch_prev;
            ch_prev    <= CH_ACTUAL;
          end
        end
        CONVST: begin
          if (cnt == CONVST_LAST) begin
            state      <= CONV_WAIT;
            cnt        <= '0;
            ADC_CONVST <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        CONV_WAIT: begin
          if (cnt == CONV_LAST) begin
            state <= SHIFT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (sck_last) begin
            state      <= DONE;
            FRAME_FLAG <= 1'b1;
            prime      <= 1'b1;
            if (publish) begin
              DATA       <= pub_data;
              CH_TAG     <= frame_tag;
              DATA_VALID <= 1'b1;
              OVERRUN    <= DATA_VALID & ~DATA_READY;
            end
          end
        end
        DONE: begin
          if (ENABLE) begin
            state      <= CONVST;
            cnt        <= '0;
            ADC_CONVST <= 1'b1;
            frame_tag  <= ch_prev;
            ch_prev    <= CH_ACTUAL;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_FRAME_BANK_EN
  logic [ADC_BITS-1:0] bank [NUM_CH];

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++)
        bank[i] <= '0;
      BANK_DATA <= '0;
    end else begin
      if (publish && (int'(frame_tag) < NUM_CH))
        bank[frame_tag] <= pub_data;
      BANK_DATA <= (int'(BANK_ADDR) < NUM_CH) ? bank[BANK_ADDR] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_adc_frame_capture.sv
// tb/tb_adc_frame_capture.sv - directed-vector bench for adc_frame_capture with a serial ADC model
module tb_adc_frame_capture;

  localparam int FRAME = 131;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        ready = 1'b0;
  logic        x_en = 1'b0;
  logic [3:0]  ch = 4'd0;
  logic [11:0] sdo_word = 12'h000;
  int          bit_idx = -1;
  logic        sdo;
  logic        convst, sck, flag, valid, overrun, busy;
  logic [11:0] data;
  logic [3:0]  tag;
`ifdef ADC_FRAME_BANK_EN
  logic [3:0]  bank_addr = 4'd0;
  logic [11:0] bank_data;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  // ADC model: MSB presented after CONVST, next bit after each SCK falling edge.
  assign sdo = (bit_idx >= 0 && bit_idx < 12) ? sdo_word[bit_idx[3:0]] : 1'b0;
  always @(posedge convst or negedge sck)
    if (convst) bit_idx = 11;
    else        bit_idx = bit_idx - 1;

  adc_frame_capture dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .ENABLE     (en),
    .CH_ACTUAL  (ch),
    .ADC_SDO    (sdo),
    .ADC_CONVST (convst),
    .ADC_SCK    (sck),
    .FRAME_FLAG (flag),
    .DATA       (data),
    .CH_TAG     (tag),
    .DATA_VALID (valid),
    .DATA_READY (ready),
    .OVERRUN    (overrun),
    .BUSY       (busy)
`ifdef ADC_FRAME_BANK_EN
    ,
    .BANK_ADDR  (bank_addr),
    .BANK_DATA  (bank_data)
`endif
  );

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_flag(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!flag && cycles < limit);
    if (!flag) check_eq("frame_flag_timeout", flag, 1);
  endtask

  // SCK pulse count per frame at three divider settings.
  for (genvar g = 0; g < 3; g++) begin : g_x
    localparam int DIV = (g == 0) ? 1 : (g == 1) ? 2 : 5;
    logic        xsck, xcv, xff, xdv, xov, xbz;
    logic [11:0] xd;
    logic [3:0]  xt;
    logic        prev_sck = 1'b0;
    int          falls = 0;
    int          frames = 0;
`ifdef ADC_FRAME_BANK_EN
    logic [11:0] xbd;
`endif

    adc_frame_capture #(.SCK_DIV(DIV)) u_x (
      .CLOCK_50   (clk),
      .RESET      (rst),
      .ENABLE     (x_en),
      .CH_ACTUAL  (4'd0),
      .ADC_SDO    (1'b0),
      .ADC_CONVST (xcv),
      .ADC_SCK    (xsck),
      .FRAME_FLAG (xff),
      .DATA       (xd),
      .CH_TAG     (xt),
      .DATA_VALID (xdv),
      .DATA_READY (1'b1),
      .OVERRUN    (xov),
      .BUSY       (xbz)
`ifdef ADC_FRAME_BANK_EN
      ,
      .BANK_ADDR  (4'd0),
      .BANK_DATA  (xbd)
`endif
    );

    always @(negedge clk) begin
      if (prev_sck && !xsck) falls++;
      prev_sck = xsck;
      if (xff) begin
        check_eq($sformatf("sck_falls_div%0d", DIV), falls, 12);
        falls = 0;
        frames++;
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {convst, sck, flag, valid, overrun, busy, data, tag}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", busy, 0);

    ch = 4'd3; sdo_word = 12'hA5C; en = 1'b1;
    wait_flag(300, n);
    check_eq("prime_no_valid", valid, 0);
    ch = 4'd7;
    @(negedge clk);
    check_eq("flag_width", flag, 0);
    check_eq("next_convst", convst, 1);
    wait_flag(300, n);
    check_eq("frame_period", n + 1, FRAME);
    check_eq("f2_result", {valid, tag, data}, {1'b1, 4'd3, 12'hA5C});

    sdo_word = 12'h3C1;
    wait_flag(300, n);
    check_eq("f3_overrun", overrun, 1);
    check_eq("f3_result", {valid, tag, data}, {1'b1, 4'd7, 12'h3C1});
    ch = 4'd9; sdo_word = 12'h5A3;
    @(negedge clk);
    check_eq("overrun_width", overrun, 0);
    ready = 1'b1;
    @(negedge clk);
    check_eq("ready_clears_valid", valid, 0);
    ready = 1'b0;
    wait_flag(300, n);
    check_eq("f4_result", {overrun, valid, tag, data}, {1'b0, 1'b1, 4'd7, 12'h5A3});

    sdo_word = 12'h0F0;
    repeat (FRAME - 1) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    check_eq("f5_flag_aligned", flag, 1);
    check_eq("f5_result", {overrun, valid, tag, data}, {1'b0, 1'b1, 4'd9, 12'h0F0});

    sdo_word = 12'h999;
    repeat (10) @(negedge clk);
    en = 1'b0;
    wait_flag(300, n);
    check_eq("f6_result", {overrun, valid, tag, data}, {1'b0, 1'b1, 4'd9, 12'h999});
    ready = 1'b0;
    @(negedge clk);
    check_eq("idle_after_disable", busy, 0);
    repeat (5) @(negedge clk);
    check_eq("stays_idle", {busy, convst}, 0);

    en = 1'b1;
    n = 0;
    while (!sck && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("pre_reset_state", {sck, valid, busy}, 3'b111);
    #2 rst = 1'b1;
    #1 check_eq("async_reset", {sck, convst, valid, busy}, 0);
    @(negedge clk);
    rst = 1'b0; ch = 4'd14; sdo_word = 12'h7E1;
    wait_flag(300, n);
    check_eq("post_reset_prime", valid, 0);
    wait_flag(300, n);
    check_eq("f9_tag_passthrough", {valid, tag, data}, {1'b1, 4'd14, 12'h7E1});
    en = 1'b0;

`ifdef ADC_FRAME_BANK_EN
    repeat (3) @(negedge clk);
    ch = 4'd0; en = 1'b1;
    for (int f = 0; f < 14; f++) begin
      wait_flag(300, n);
      ch = 4'(f + 1);
      sdo_word = 12'h100 + 12'(f);
    end
    en = 1'b0;
    for (int k = 0; k < 14; k++) begin
      bank_addr = 4'(k);
      @(negedge clk);
      check_eq($sformatf("bank_read_%0d", k), bank_data, (k < 13) ? 12'h100 + 12'(k) : 12'h000);
    end
`endif

    repeat (3) @(negedge clk);
    x_en = 1'b1;
    n = 0;
    while (g_x[2].frames < 26 && n < 7000) begin
      @(negedge clk);
      n++;
    end
    check_eq("x_frames_done", 32'(g_x[2].frames >= 26), 1);
    x_en = 1'b0;
    repeat (250) @(negedge clk);
    check_eq("x_div1_idle", {g_x[0].xsck, g_x[0].xcv, g_x[0].xbz, g_x[0].xov, g_x[0].xdv, g_x[0].xt, g_x[0].xd}, 0);
    check_eq("x_div2_idle", {g_x[1].xsck, g_x[1].xcv, g_x[1].xbz, g_x[1].xov, g_x[1].xdv, g_x[1].xt, g_x[1].xd}, 0);
    check_eq("x_div5_idle", {g_x[2].xsck, g_x[2].xcv, g_x[2].xbz, g_x[2].xov, g_x[2].xdv, g_x[2].xt, g_x[2].xd}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
